reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order retirement queue for the Tomasulo core. Dispatcher allocates one entry/cycle
//  (the entry tag is the ROB dest sent to register); CDB marks entries ready. The ROB commits one
//  entry/cycle in order to register (rob_en/reg_pos/dest/value) and lsb. On branch mispredict it flushes.
// PARAMETERS
//  ROB_DEPTH   16  entries; power of two
//  ROB_IDX_W   4   log2(ROB_DEPTH); tag width, equals `ROB_WIDTH
//  XLEN        32  data/PC width, equals `INSTRUCTION_WIDTH
//  REG_IDX_W   5   architectural register index, equals `REGISTER_WIDTH
// PORTS
//  clk_in                 in   1      clock
//  rst_in                 in   1      synchronous reset, active-high
//  rdy_in                 in   1      global enable; low = hold all state, commit/flush outputs 0
//  dispatcher_en_in       in   1      allocate entry at tail this cycle
//  dispatcher_rd_in       in   REG    destination register (0 = no register write)
//  dispatcher_type_in     in   2      0=ALU/load, 1=store, 2=branch
//  dispatcher_pred_in     in   1      predicted taken (branch only)
//  rob_tail_out           out  IDX    tag the next allocation receives
//  rob_full_out           out  1      count==ROB_DEPTH; dispatcher must not assert en
//  query1_dest_in         in   IDX    operand tag lookup, port 1 (same set for port 2)
//  query1_ready_out       out  1      entry valid and value ready
//  query1_value_out       out  XLEN   entry value
//  cdb_en_in              in   1      writeback valid
//  cdb_dest_in            in   IDX    tag being written back
//  cdb_value_in           in   XLEN   result (branch: link value)
//  cdb_taken_in           in   1      resolved branch direction
//  cdb_target_in          in   XLEN   correct next PC for a branch
//  register_en_out        out  1      commit write to register file (1-cycle pulse)
//  register_reg_pos_out   out  REG    rd of committed entry
//  register_dest_out      out  IDX    tag of committed entry
//  register_value_out     out  XLEN   committed value
//  lsb_commit_en_out      out  1      store at head may write memory (1-cycle pulse)
//  lsb_commit_dest_out    out  IDX    tag of that store
//  flush_out              out  1      mispredict flush (1-cycle pulse)
//  flush_pc_out           out  XLEN   redirect PC, valid with flush_out
// BEHAVIOUR
//  - Reset: head=tail=count=0, all valid/ready bits 0; every output 0 (rob_full_out=0).
//  - Entry: valid, ready, type, rd, pred, taken, value, target. Pointers wrap mod ROB_DEPTH.
//  - Dispatch: en && !full -> entry[tail] valid, ready=0, fields latched; tail++. En while full: dropped.
//  - CDB: en && entry[dest].valid -> ready=1, value/taken/target latched; write to invalid entry ignored.
//  - Commit (from registered state): count>0 && entry[head].ready -> one commit per cycle, head++.
//    ALU/load: register_en_out=1 next cycle only if rd!=0; dest/value/reg_pos driven with it.
//    store: lsb_commit_en_out=1 next cycle. branch: rd!=0 writes link value as ALU.
//  - Latency: CDB write at edge N -> earliest commit pulse after edge N+1 (no same-cycle CDB->commit).
//  - Mispredict: committing branch with taken!=pred -> flush_out=1, flush_pc_out=target next cycle;
//    head=tail=count=0 and all valid cleared same edge; same-cycle dispatch and CDB discarded.
//  - Simultaneous dispatch+commit: count unchanged; at full, commit frees slot but full stays 1 that cycle.
//  - Queries combinational: ready = valid&&ready bit of entry[dest]; value = its value.
//  - rdy_in low: no alloc, CDB or commit; pulses forced 0. Reset mid-operation discards all entries.
// CONFIGURATION
//  ROB_BYPASS_EN defined: query port returns ready=1, value=cdb_value_in when cdb_en_in and
//  cdb_dest_in==query tag and entry valid (same-cycle forward). Undefined: query sees CDB data next cycle.
// STRUCTURE
//  Shared define.vh: ROB_DEPTH/ROB_WIDTH, type codes ROB_TYPE_ALU/STORE/BRANCH, `NULL.
//  One sub-module natural: rob_query_port (tag lookup + optional bypass), instantiated twice.
// TESTING
//  1 Dispatch rd=5 tag0; CDB tag0 value 0x1234 -> next+1 cycle register_en=1, pos=5, dest=0, val=0x1234.
//  2 Fill 16 entries -> rob_full_out=1, 17th dispatch dropped, rob_tail_out stays 0 (wrapped).
//  3 CDB completes tags 2,1 before 0 -> commits strictly in order 0,1,2 on consecutive cycles.
//  4 Branch pred=0, CDB taken=1 target 0x100 -> flush_out=1, flush_pc=0x100; next cycle count=0, tail=0.
//  5 Query tag3 during CDB tag3 val 7 -> ready=1/val 7 with ROB_BYPASS_EN, ready=0 without.
//  6 Store tag0 ready -> lsb_commit_en=1 dest=0, register_en=0; rd=0 ALU commit -> no register_en.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizes for the reorder buffer.
// Entry layout, type codes and the mispredict helper.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int ROB_CNT_W = ROB_IDX_W + 1;

  typedef enum logic [1:0] {
    ROB_TYPE_ALU    = 2'd0,
    ROB_TYPE_STORE  = 2'd1,
    ROB_TYPE_BRANCH = 2'd2
  } rob_type_e;

  typedef struct packed {
    logic                 valid;
    logic                 ready;
    rob_type_e            typ;
    logic [REG_IDX_W-1:0] rd;
    logic                 pred;
    logic                 taken;
    logic [XLEN-1:0]      value;
    logic [XLEN-1:0]      target;
  } rob_entry_t;

  function automatic logic is_mispredict(
    input rob_entry_t e
  );
    return (e.typ == ROB_TYPE_BRANCH)
        && (e.taken != e.pred);
  endfunction

  function automatic logic writes_reg(
    input rob_entry_t e
  );
    return (e.typ != ROB_TYPE_STORE)
        && (e.rd != '0);
  endfunction

endpackage

// File: rtl/reorder_buffer_query.sv
// Operand tag lookup into the reorder buffer.
// ROB_BYPASS_EN forwards a same-cycle CDB result.
module reorder_buffer_query
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_IDX_W-1:0] dest_in,
  input  logic [ROB_DEPTH-1:0] valid_in,
  input  logic [ROB_DEPTH-1:0] ready_in,
  input  logic [XLEN-1:0]      value_in [ROB_DEPTH],
`ifdef ROB_BYPASS_EN
  input  logic                 cdb_en_in,
  input  logic [ROB_IDX_W-1:0] cdb_dest_in,
  input  logic [XLEN-1:0]      cdb_value_in,
`endif
  output logic                 ready_out,
  output logic [XLEN-1:0]      value_out
);

  logic hit_valid;

  assign hit_valid = valid_in[dest_in];

  // Select stored entry state, optionally overridden by the CDB.
  always_comb begin
    ready_out = hit_valid && ready_in[dest_in];
    value_out = value_in[dest_in];
`ifdef ROB_BYPASS_EN
    if (cdb_en_in && hit_valid
        && (cdb_dest_in == dest_in)) begin
      ready_out = 1'b1;
      value_out = cdb_value_in;
    end
`endif
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue (Tomasulo ROB).
// Optional macro ROB_BYPASS_EN: same-cycle CDB forward.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 dispatcher_en_in,
  input  logic [REG_IDX_W-1:0] dispatcher_rd_in,
  input  logic [1:0]           dispatcher_type_in,
  input  logic                 dispatcher_pred_in,
  output logic [ROB_IDX_W-1:0] rob_tail_out,
  output logic                 rob_full_out,
  input  logic [ROB_IDX_W-1:0] query1_dest_in,
  output logic                 query1_ready_out,
  output logic [XLEN-1:0]      query1_value_out,
  input  logic [ROB_IDX_W-1:0] query2_dest_in,
  output logic                 query2_ready_out,
  output logic [XLEN-1:0]      query2_value_out,
  input  logic                 cdb_en_in,
  input  logic [ROB_IDX_W-1:0] cdb_dest_in,
  input  logic [XLEN-1:0]      cdb_value_in,
  input  logic                 cdb_taken_in,
  input  logic [XLEN-1:0]      cdb_target_in,
  output logic                 register_en_out,
  output logic [REG_IDX_W-1:0] register_reg_pos_out,
  output logic [ROB_IDX_W-1:0] register_dest_out,
  output logic [XLEN-1:0]      register_value_out,
  output logic                 lsb_commit_en_out,
  output logic [ROB_IDX_W-1:0] lsb_commit_dest_out,
  output logic                 flush_out,
  output logic [XLEN-1:0]      flush_pc_out
);

  localparam logic [ROB_CNT_W-1:0] FULL_CNT =
    ROB_CNT_W'(ROB_DEPTH);

  rob_entry_t           ent_q [ROB_DEPTH];
  rob_entry_t           ent_d [ROB_DEPTH];
  logic [ROB_IDX_W-1:0] head_q, head_d;
  logic [ROB_IDX_W-1:0] tail_q, tail_d;
  logic [ROB_CNT_W-1:0] count_q, count_d;

  logic                 reg_en_q, reg_en_d;
  logic [REG_IDX_W-1:0] reg_pos_q, reg_pos_d;
  logic [ROB_IDX_W-1:0] reg_dest_q, reg_dest_d;
  logic [XLEN-1:0]      reg_val_q, reg_val_d;
  logic                 lsb_en_q, lsb_en_d;
  logic [ROB_IDX_W-1:0] lsb_dest_q, lsb_dest_d;
  logic                 flush_q, flush_d;
  logic [XLEN-1:0]      flush_pc_q, flush_pc_d;

  rob_entry_t           head_ent;
  logic                 full;
  logic                 do_alloc;
  logic                 do_commit;
  logic                 mispredict;

  logic [ROB_DEPTH-1:0] valid_vec;
  logic [ROB_DEPTH-1:0] ready_vec;
  logic [XLEN-1:0]      value_vec [ROB_DEPTH];

  assign head_ent = ent_q[head_q];
  assign full     = (count_q == FULL_CNT);

  // Flatten entry state for the query ports.
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
      ready_vec[i] = ent_q[i].ready;
      value_vec[i] = ent_q[i].value;
    end
  end

  // Dispatch, writeback, in-order commit and flush.
  always_comb begin
    ent_d      = ent_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    reg_en_d   = 1'b0;
    reg_pos_d  = '0;
    reg_dest_d = '0;
    reg_val_d  = '0;
    lsb_en_d   = 1'b0;
    lsb_dest_d = '0;
    flush_d    = 1'b0;
    flush_pc_d = '0;
    do_alloc   = 1'b0;
    do_commit  = 1'b0;
    mispredict = 1'b0;
    if (rdy_in) begin
      do_commit = (count_q != '0)
               && head_ent.valid
               && head_ent.ready;
      mispredict = do_commit
                && is_mispredict(head_ent);
      do_alloc = dispatcher_en_in && !full;

      if (cdb_en_in && ent_q[cdb_dest_in].valid) begin
        ent_d[cdb_dest_in].ready  = 1'b1;
        ent_d[cdb_dest_in].value  = cdb_value_in;
        ent_d[cdb_dest_in].taken  = cdb_taken_in;
        ent_d[cdb_dest_in].target = cdb_target_in;
      end

      if (do_alloc) begin
        ent_d[tail_q].valid  = 1'b1;
        ent_d[tail_q].ready  = 1'b0;
        ent_d[tail_q].typ    =
          rob_type_e'(dispatcher_type_in);
        ent_d[tail_q].rd     = dispatcher_rd_in;
        ent_d[tail_q].pred   = dispatcher_pred_in;
        ent_d[tail_q].taken  = 1'b0;
        ent_d[tail_q].value  = '0;
        ent_d[tail_q].target = '0;
      end

      if (do_commit) begin
        ent_d[head_q].valid = 1'b0;
        ent_d[head_q].ready = 1'b0;
        head_d = head_q + 1'b1;
        if (writes_reg(head_ent)) begin
          reg_en_d   = 1'b1;
          reg_pos_d  = head_ent.rd;
          reg_dest_d = head_q;
          reg_val_d  = head_ent.value;
        end
        if (head_ent.typ == ROB_TYPE_STORE) begin
          lsb_en_d   = 1'b1;
          lsb_dest_d = head_q;
        end
      end

      tail_d  = tail_q + ROB_IDX_W'(do_alloc);
      count_d = count_q
              + ROB_CNT_W'(do_alloc)
              - ROB_CNT_W'(do_commit);

      if (mispredict) begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
          ent_d[i].valid = 1'b0;
          ent_d[i].ready = 1'b0;
        end
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
        flush_d    = 1'b1;
        flush_pc_d = head_ent.target;
      end
    end
  end

  // State and registered commit/flush pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      reg_en_q   <= 1'b0;
      reg_pos_q  <= '0;
      reg_dest_q <= '0;
      reg_val_q  <= '0;
      lsb_en_q   <= 1'b0;
      lsb_dest_q <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      ent_q      <= ent_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      reg_en_q   <= reg_en_d;
      reg_pos_q  <= reg_pos_d;
      reg_dest_q <= reg_dest_d;
      reg_val_q  <= reg_val_d;
      lsb_en_q   <= lsb_en_d;
      lsb_dest_q <= lsb_dest_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  assign rob_tail_out         = tail_q;
  assign rob_full_out         = full;
  assign register_en_out      = reg_en_q;
  assign register_reg_pos_out = reg_pos_q;
  assign register_dest_out    = reg_dest_q;
  assign register_value_out   = reg_val_q;
  assign lsb_commit_en_out    = lsb_en_q;
  assign lsb_commit_dest_out  = lsb_dest_q;
  assign flush_out            = flush_q;
  assign flush_pc_out         = flush_pc_q;

  reorder_buffer_query u_query1 (
    .dest_in      (query1_dest_in),
    .valid_in     (valid_vec),
    .ready_in     (ready_vec),
    .value_in     (value_vec),
`ifdef ROB_BYPASS_EN
    .cdb_en_in    (cdb_en_in),
    .cdb_dest_in  (cdb_dest_in),
    .cdb_value_in (cdb_value_in),
`endif
    .ready_out    (query1_ready_out),
    .value_out    (query1_value_out)
  );

  reorder_buffer_query u_query2 (
    .dest_in      (query2_dest_in),
    .valid_in     (valid_vec),
    .ready_in     (ready_vec),
    .value_in     (value_vec),
`ifdef ROB_BYPASS_EN
    .cdb_en_in    (cdb_en_in),
    .cdb_dest_in  (cdb_dest_in),
    .cdb_value_in (cdb_value_in),
`endif
    .ready_out    (query2_ready_out),
    .value_out    (query2_value_out)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer.
// Queue model checked every cycle plus directed literals.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        dispatcher_en_in;
  logic [4:0]  dispatcher_rd_in;
  logic [1:0]  dispatcher_type_in;
  logic        dispatcher_pred_in;
  logic [3:0]  rob_tail_out;
  logic        rob_full_out;
  logic [3:0]  query1_dest_in;
  logic        query1_ready_out;
  logic [31:0] query1_value_out;
  logic [3:0]  query2_dest_in;
  logic        query2_ready_out;
  logic [31:0] query2_value_out;
  logic        cdb_en_in;
  logic [3:0]  cdb_dest_in;
  logic [31:0] cdb_value_in;
  logic        cdb_taken_in;
  logic [31:0] cdb_target_in;
  logic        register_en_out;
  logic [4:0]  register_reg_pos_out;
  logic [3:0]  register_dest_out;
  logic [31:0] register_value_out;
  logic        lsb_commit_en_out;
  logic [3:0]  lsb_commit_dest_out;
  logic        flush_out;
  logic [31:0] flush_pc_out;

  int n_total = 0;
  int n_pass  = 0;
  bit bypass  = 1'b0;

  reorder_buffer dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .rdy_in               (rdy_in),
    .dispatcher_en_in     (dispatcher_en_in),
    .dispatcher_rd_in     (dispatcher_rd_in),
    .dispatcher_type_in   (dispatcher_type_in),
    .dispatcher_pred_in   (dispatcher_pred_in),
    .rob_tail_out         (rob_tail_out),
    .rob_full_out         (rob_full_out),
    .query1_dest_in       (query1_dest_in),
    .query1_ready_out     (query1_ready_out),
    .query1_value_out     (query1_value_out),
    .query2_dest_in       (query2_dest_in),
    .query2_ready_out     (query2_ready_out),
    .query2_value_out     (query2_value_out),
    .cdb_en_in            (cdb_en_in),
    .cdb_dest_in          (cdb_dest_in),
    .cdb_value_in         (cdb_value_in),
    .cdb_taken_in         (cdb_taken_in),
    .cdb_target_in        (cdb_target_in),
    .register_en_out      (register_en_out),
    .register_reg_pos_out (register_reg_pos_out),
    .register_dest_out    (register_dest_out),
    .register_value_out   (register_value_out),
    .lsb_commit_en_out    (lsb_commit_en_out),
    .lsb_commit_dest_out  (lsb_commit_dest_out),
    .flush_out            (flush_out),
    .flush_pc_out         (flush_pc_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    logic [1:0]  typ;
    logic        pred;
    logic        ready;
    logic        taken;
    logic [31:0] value;
    logic [31:0] target;
  } m_t;

  m_t          q[$];
  logic [3:0]  m_tail = '0;
  bit          live = 1'b0;
  logic        e_reg_en = 0;
  logic [4:0]  e_reg_pos = 0;
  logic [3:0]  e_reg_dest = 0;
  logic [31:0] e_reg_val = 0;
  logic        e_lsb_en = 0;
  logic [3:0]  e_lsb_dest = 0;
  logic        e_flush = 0;
  logic [31:0] e_flush_pc = 0;

  always @(posedge clk_in) begin
    m_t c;
    bit cm;
    e_reg_en = 0;
    e_lsb_en = 0;
    e_flush  = 0;
    if (rst_in) begin
      q.delete();
      m_tail = '0;
      live = 1'b1;
    end else if (rdy_in) begin
      cm = (q.size() > 0) && q[0].ready;
      if (cm) c = q[0];
      if (cdb_en_in)
        foreach (q[i])
          if (q[i].tag == cdb_dest_in) begin
            q[i].ready  = 1'b1;
            q[i].value  = cdb_value_in;
            q[i].taken  = cdb_taken_in;
            q[i].target = cdb_target_in;
          end
      if (dispatcher_en_in && q.size() < 16) begin
        q.push_back('{m_tail, dispatcher_rd_in,
                      dispatcher_type_in,
                      dispatcher_pred_in, 1'b0, 1'b0,
                      32'h0, 32'h0});
        m_tail = m_tail + 4'd1;
      end
      if (cm) begin
        void'(q.pop_front());
        if (c.typ != 2'd1 && c.rd != 0) begin
          e_reg_en   = 1;
          e_reg_pos  = c.rd;
          e_reg_dest = c.tag;
          e_reg_val  = c.value;
        end
        if (c.typ == 2'd1) begin
          e_lsb_en   = 1;
          e_lsb_dest = c.tag;
        end
        if (c.typ == 2'd2 && c.taken != c.pred) begin
          q.delete();
          m_tail     = '0;
          e_flush    = 1;
          e_flush_pc = c.target;
        end
      end
    end
  end

  function automatic void qexp(input logic [3:0] t,
                               output logic r,
                               output logic [31:0] v);
    r = 0;
    v = 0;
    foreach (q[i])
      if (q[i].tag == t) begin
        if (bypass && cdb_en_in && cdb_dest_in == t) begin
          r = 1;
          v = cdb_value_in;
        end else if (q[i].ready) begin
          r = 1;
          v = q[i].value;
        end
      end
  endfunction

  // Compare DUT against the model every cycle.
  always @(negedge clk_in) begin
    logic        r;
    logic [31:0] v;
    if (live) begin
      chk("tail", rob_tail_out, m_tail);
      chk("full", rob_full_out, q.size() == 16);
      chk("reg_en", register_en_out, e_reg_en);
      if (e_reg_en) begin
        chk("reg_pos", register_reg_pos_out, e_reg_pos);
        chk("reg_dest", register_dest_out, e_reg_dest);
        chk("reg_val", register_value_out, e_reg_val);
      end
      chk("lsb_en", lsb_commit_en_out, e_lsb_en);
      if (e_lsb_en)
        chk("lsb_dest", lsb_commit_dest_out, e_lsb_dest);
      chk("flush", flush_out, e_flush);
      if (e_flush)
        chk("flush_pc", flush_pc_out, e_flush_pc);
      qexp(query1_dest_in, r, v);
      chk("q1_ready", query1_ready_out, r);
      if (r) chk("q1_value", query1_value_out, v);
      qexp(query2_dest_in, r, v);
      chk("q2_ready", query2_ready_out, r);
      if (r) chk("q2_value", query2_value_out, v);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    dispatcher_en_in = 0;
    cdb_en_in = 0;
  endtask

  task automatic disp(input logic [4:0] rd,
                      input logic [1:0] typ,
                      input logic pred);
    dispatcher_en_in   = 1;
    dispatcher_rd_in   = rd;
    dispatcher_type_in = typ;
    dispatcher_pred_in = pred;
  endtask

  task automatic cdb(input logic [3:0] d,
                     input logic [31:0] val,
                     input logic tk,
                     input logic [31:0] tgt);
    cdb_en_in     = 1;
    cdb_dest_in   = d;
    cdb_value_in  = val;
    cdb_taken_in  = tk;
    cdb_target_in = tgt;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1;
    cyc();
    rst_in = 0;
  endtask

  initial begin
`ifdef ROB_BYPASS_EN
    bypass = 1'b1;
`endif
    rst_in = 1;
    rdy_in = 1;
    dispatcher_rd_in = 0;
    dispatcher_type_in = 0;
    dispatcher_pred_in = 0;
    query1_dest_in = 0;
    query2_dest_in = 0;
    cdb_dest_in = 0;
    cdb_value_in = 0;
    cdb_taken_in = 0;
    cdb_target_in = 0;
    idle();
    cyc();
    cyc();
    rst_in = 0;
    chk("rst_tail", rob_tail_out, 0);
    chk("rst_full", rob_full_out, 0);
    chk("rst_reg_en", register_en_out, 0);
    chk("rst_flush", flush_out, 0);

    // 1: single ALU op, CDB, then commit
    disp(5, 0, 0); cyc(); idle();
    cdb(0, 32'h1234, 0, 0); cyc(); idle();
    chk("t1_no_same_cycle", register_en_out, 0);
    cyc();
    chk("t1_en", register_en_out, 1);
    chk("t1_pos", register_reg_pos_out, 5);
    chk("t1_dest", register_dest_out, 0);
    chk("t1_val", register_value_out, 32'h1234);
    cyc();
    chk("t1_pulse", register_en_out, 0);

    // 2: fill, overflow drop, drain
    do_reset();
    for (int i = 0; i < 16; i++) begin
      disp(5'(i + 1), 0, 0); cyc();
    end
    idle();
    chk("t2_full", rob_full_out, 1);
    chk("t2_tail", rob_tail_out, 0);
    disp(9, 0, 0); cyc(); idle();
    chk("t2_drop_tail", rob_tail_out, 0);
    chk("t2_drop_full", rob_full_out, 1);
    for (int i = 0; i < 16; i++) begin
      cdb(4'(i), 32'h100 + i, 0, 0);
      if (i == 1) disp(7, 0, 0);
      else dispatcher_en_in = 0;
      cyc();
    end
    idle();
    repeat (3) cyc();
    chk("t2_drain_full", rob_full_out, 0);
    chk("t2_drain_tail", rob_tail_out, 0);

    // 3: out-of-order completion, in-order commit
    do_reset();
    disp(1, 0, 0); cyc();
    disp(2, 0, 0); cyc();
    disp(3, 0, 0); cyc(); idle();
    cdb(2, 32'h22, 0, 0); cyc();
    cdb(1, 32'h11, 0, 0); cyc();
    chk("t3_wait", register_en_out, 0);
    cdb(0, 32'h33, 0, 0); cyc(); idle();
    chk("t3_lat", register_en_out, 0);
    cyc();
    chk("t3_c0_dest", register_dest_out, 0);
    chk("t3_c0_val", register_value_out, 32'h33);
    cyc();
    chk("t3_c1_dest", register_dest_out, 1);
    chk("t3_c1_val", register_value_out, 32'h11);
    cyc();
    chk("t3_c2_dest", register_dest_out, 2);
    chk("t3_c2_val", register_value_out, 32'h22);

    // 4: mispredict flush, then correct branch
    do_reset();
    disp(0, 2, 0); cyc();
    disp(3, 0, 0); cyc(); idle();
    cdb(0, 0, 1, 32'h100); cyc(); idle();
    chk("t4_pre", flush_out, 0);
    disp(4, 0, 0); cyc(); idle();
    chk("t4_flush", flush_out, 1);
    chk("t4_pc", flush_pc_out, 32'h100);
    chk("t4_tail", rob_tail_out, 0);
    chk("t4_full", rob_full_out, 0);
    cdb(1, 32'h55, 0, 0); cyc(); idle();
    chk("t4_pulse", flush_out, 0);
    disp(6, 0, 0); cyc();
    chk("t4_realloc", rob_tail_out, 1);
    disp(1, 2, 1); cyc(); idle();
    cdb(0, 32'h5, 0, 0); cyc();
    cdb(1, 32'h44, 1, 32'h200); cyc(); idle();
    chk("t4_alu_val", register_value_out, 32'h5);
    cyc();
    chk("t4_link_en", register_en_out, 1);
    chk("t4_link_val", register_value_out, 32'h44);
    chk("t4_no_flush", flush_out, 0);

    // 5: query during CDB write
    do_reset();
    for (int i = 0; i < 4; i++) begin
      disp(5'(i + 1), 0, 0); cyc();
    end
    idle();
    query1_dest_in = 3;
    query2_dest_in = 2;
    cdb(3, 32'h7, 0, 0);
    #1;
    chk("t5_same_ready", query1_ready_out, bypass);
    if (bypass)
      chk("t5_same_val", query1_value_out, 32'h7);
    chk("t5_q2_ready", query2_ready_out, 0);
    cyc(); idle();
    chk("t5_next_ready", query1_ready_out, 1);
    chk("t5_next_val", query1_value_out, 32'h7);

    // 6: store commit and rd=0 ALU commit
    do_reset();
    disp(0, 1, 0); cyc();
    disp(0, 0, 0); cyc(); idle();
    cdb(0, 32'h9, 0, 0); cyc();
    cdb(1, 32'hA, 0, 0); cyc(); idle();
    chk("t6_lsb_en", lsb_commit_en_out, 1);
    chk("t6_lsb_dest", lsb_commit_dest_out, 0);
    chk("t6_st_reg", register_en_out, 0);
    cyc();
    chk("t6_rd0_reg", register_en_out, 0);
    chk("t6_rd0_lsb", lsb_commit_en_out, 0);

    // 7: rdy_in low freezes everything
    do_reset();
    disp(8, 0, 0); cyc(); idle();
    cdb(0, 32'h77, 0, 0); cyc(); idle();
    rdy_in = 0;
    disp(9, 0, 0);
    cyc(); cyc();
    chk("t7_hold_en", register_en_out, 0);
    chk("t7_hold_tail", rob_tail_out, 1);
    idle();
    rdy_in = 1;
    cyc();
    chk("t7_en", register_en_out, 1);
    chk("t7_val", register_value_out, 32'h77);

    // 8: reset mid-operation
    disp(2, 0, 0); cyc();
    do_reset();
    chk("t8_tail", rob_tail_out, 0);
    query1_dest_in = 0;
    #1;
    chk("t8_query", query1_ready_out, 0);
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
